// File: rtl/sdf_stage_ctrl.sv
// Control sequencer for one radix-2 single-path delay-feedback FFT stage.
// Generates delay-line shift, butterfly/pass phase, twiddle addressing, frame drain and length errors.
module sdf_stage_ctrl #(
  parameter int DELAY   = 512,
  parameter int CNT_W   = 10,
  parameter int TW_W    = 9,
  parameter int TW_STEP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic             shift_en,
  output logic             bf_en,
  output logic             tw_en,
  output logic [TW_W-1:0]  tw_addr,
  output logic             out_valid,
  output logic [CNT_W-1:0] cnt,
  output logic             busy,
  output logic             frame_done,
  output logic             err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] FLUSH = 2'd3;

  localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(DELAY - 1);
  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(2 * DELAY - 1);

  logic [1:0] state;
  logic       accept;
  logic       in_frame;

  // Twiddle index for the lower-half position, wrapped to the ROM width.
  function automatic logic [TW_W-1:0] tw_index(input logic [CNT_W-2:0] pos);
    logic [31:0] prod;
    prod = 32'(pos) * 32'(TW_STEP);
    return prod[TW_W-1:0];
  endfunction

  assign in_ready  = (state != FLUSH);
  assign accept    = in_valid && in_ready;
  assign in_frame  = (state == FILL) || (state == RUN);
  assign shift_en  = (state == FLUSH) ? 1'b1 : accept;
  assign bf_en     = shift_en && cnt[CNT_W-1] && in_frame;
  assign out_valid = shift_en && ((state == RUN) || (state == FLUSH));
  assign tw_en     = out_valid && !cnt[CNT_W-1];
  assign tw_addr   = tw_en ? tw_index(cnt[CNT_W-2:0]) : '0;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      frame_done <= (state == FLUSH) && (cnt == CNT_HALF_LAST);
      // in_last is only legal on the final sample of a full frame in RUN.
      if (accept && in_last && in_frame && !((state == RUN) && (cnt == CNT_LAST)))
        err <= 1'b1;
      if (shift_en) begin
        cnt <= cnt + CNT_W'(1);
        case (state)
          IDLE:  state <= FILL;
          FILL:  if (cnt == CNT_HALF_LAST) state <= RUN;
          RUN:   if ((cnt == CNT_LAST) && in_last) state <= FLUSH;
          FLUSH: begin
            if (cnt == CNT_HALF_LAST) begin
              state <= IDLE;
              cnt   <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Bench for sdf_stage_ctrl: directed and random steps against a sample-index reference model,
// plus a full-size default-parameter frame.
module tb_sdf_stage_ctrl;

  localparam int D    = 4;
  localparam int TWW  = 3;
  localparam int STEP = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       in_valid, in_last;
  logic       in_ready, shift_en, bf_en, tw_en, out_valid, busy, frame_done, err;
  logic [2:0] tw_addr;
  logic [2:0] cnt;

  logic       b_valid, b_last;
  logic       b_in_ready, b_shift_en, b_bf_en, b_tw_en, b_out_valid, b_busy, b_frame_done, b_err;
  logic [8:0] b_tw_addr;
  logic [9:0] b_cnt;

  sdf_stage_ctrl #(.DELAY(4), .CNT_W(3), .TW_W(3), .TW_STEP(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .shift_en(shift_en), .bf_en(bf_en), .tw_en(tw_en),
    .tw_addr(tw_addr), .out_valid(out_valid), .cnt(cnt), .busy(busy),
    .frame_done(frame_done), .err(err)
  );

  sdf_stage_ctrl big (
    .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_last(b_last),
    .in_ready(b_in_ready), .shift_en(b_shift_en), .bf_en(b_bf_en), .tw_en(b_tw_en),
    .tw_addr(b_tw_addr), .out_valid(b_out_valid), .cnt(b_cnt), .busy(b_busy),
    .frame_done(b_frame_done), .err(b_err)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: counts accepted samples of the current job and drain cycles.
  int idx, fidx;
  bit flushing, err_m, fd_m;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    idx = 0; fidx = 0; flushing = 0; err_m = 0; fd_m = 0;
  endtask

  task automatic step(input bit v, input bit l);
    int pos, e_addr;
    bit e_rdy, e_sh, e_bf, e_out, e_tw, e_busy, fd_next;
    in_valid = v;
    in_last  = l;
    #1;
    if (flushing) begin
      pos = fidx; e_rdy = 0; e_sh = 1; e_out = 1; e_bf = 0; e_busy = 1;
    end else begin
      pos    = idx % (2 * D);
      e_rdy  = 1;
      e_sh   = v;
      e_busy = (idx > 0);
      e_out  = v && (idx >= D);
      e_bf   = v && (pos >= D);
    end
    e_tw   = e_out && (pos < D);
    e_addr = e_tw ? (pos * STEP) % (1 << TWW) : 0;
    chk1("in_ready", in_ready, e_rdy);
    chk1("shift_en", shift_en, e_sh);
    chk1("bf_en", bf_en, e_bf);
    chk1("out_valid", out_valid, e_out);
    chk1("tw_en", tw_en, e_tw);
    chkn("tw_addr", 32'(tw_addr), e_addr);
    chkn("cnt", 32'(cnt), pos);
    chk1("busy", busy, e_busy);
    chk1("frame_done", frame_done, fd_m);
    chk1("err", err, err_m);
    fd_next = flushing && (fidx == D - 1);
    if (flushing) begin
      fidx++;
      if (fidx == D) begin
        flushing = 0;
        idx = 0;
      end
    end else if (v) begin
      if (l && idx > 0) begin
        if ((idx + 1) % (2 * D) == 0) begin
          flushing = 1;
          fidx = 0;
        end else begin
          err_m = 1;
        end
      end
      idx++;
    end
    @(posedge clk);
    #1;
    fd_m = fd_next;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0);
  endtask

  initial begin
    rst_n = 0; in_valid = 1; in_last = 0; b_valid = 0; b_last = 0;
    model_reset();
    #1;
    chk1("rst_shift_follows_valid", shift_en, 1'b1);
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chkn("rst_cnt", 32'(cnt), 0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_frame_done", frame_done, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    in_valid = 0;
    #1;
    chk1("rst_shift_idle", shift_en, 1'b0);
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;

    // Single frame with drain
    for (int k = 1; k <= 8; k++) step(1, k == 8);
    idle(7);

    // Two frames back to back
    for (int k = 1; k <= 16; k++) step(1, k == 16);
    idle(7);

    // Stall for three cycles at cnt=5
    for (int k = 1; k <= 5; k++) step(1, 0);
    idle(3);
    for (int k = 6; k <= 8; k++) step(1, k == 8);
    idle(7);

    // Premature in_last
    for (int k = 1; k <= 8; k++) step(1, (k == 3) || (k == 8));
    idle(7);

    // Back-to-back job: sample offered while frame_done is high
    for (int k = 1; k <= 8; k++) step(1, k == 8);
    idle(4);
    for (int k = 1; k <= 8; k++) step(1, k == 8);
    idle(7);

    // Asynchronous reset during drain at cnt=2
    for (int k = 1; k <= 8; k++) step(1, k == 8);
    step(0, 0);
    step(0, 0);
    #2 rst_n = 0;
    #1;
    chk1("arst_busy", busy, 1'b0);
    chkn("arst_cnt", 32'(cnt), 0);
    chk1("arst_in_ready", in_ready, 1'b1);
    chk1("arst_out_valid", out_valid, 1'b0);
    chk1("arst_tw_en", tw_en, 1'b0);
    chkn("arst_tw_addr", 32'(tw_addr), 0);
    chk1("arst_err", err, 1'b0);
    model_reset();
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
    idle(4);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit v, l;
      v = ($urandom_range(3) != 0);
      if (!flushing && idx > 0 && ((idx + 1) % (2 * D) == 0)) l = ($urandom_range(2) == 0);
      else l = ($urandom_range(150) == 0);
      step(v, l);
    end
    idle(12);

    // Default-parameter stage: one 1024-sample frame and a 512-cycle drain
    chk1("big_idle_busy", b_busy, 1'b0);
    for (int k = 0; k < 1024; k++) begin
      b_valid = 1;
      b_last  = (k == 1023);
      #1;
      chk1("big_shift_en", b_shift_en, 1'b1);
      chk1("big_bf_en", b_bf_en, (k >= 512));
      chk1("big_out_valid", b_out_valid, (k >= 512));
      chk1("big_tw_en_frame", b_tw_en, 1'b0);
      @(posedge clk);
      #1;
    end
    b_valid = 0;
    b_last  = 0;
    for (int i = 0; i < 512; i++) begin
      #1;
      chk1("big_flush_ready", b_in_ready, 1'b0);
      chk1("big_flush_out_valid", b_out_valid, 1'b1);
      chk1("big_flush_tw_en", b_tw_en, 1'b1);
      chkn("big_flush_tw_addr", 32'(b_tw_addr), i);
      chk1("big_flush_frame_done", b_frame_done, 1'b0);
      @(posedge clk);
      #1;
    end
    chk1("big_frame_done", b_frame_done, 1'b1);
    chk1("big_busy_after", b_busy, 1'b0);
    chkn("big_cnt_after", 32'(b_cnt), 0);
    chk1("big_err", b_err, 1'b0);
    @(posedge clk);
    #1;
    chk1("big_frame_done_pulse", b_frame_done, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sdf_stage_ctrl.md
Name: sdf_stage_ctrl

Overview:
- Sequencer for one radix-2 single-path delay-feedback (SDF) stage of the 1024-point FFT: drives the shift enable of the stage's 24-bit complex delay line, selects butterfly vs. pass phase, and generates twiddle ROM addresses.
- Tracks frame boundaries, drains the delay line after the last frame, and flags frames of the wrong length.
- One instance per stage; the 512-deep stage uses the defaults.

Parameters:
- DELAY, 512, delay-line depth in samples; power of two, ≥2.
- CNT_W, 10, sample-counter width = log2(2*DELAY).
- TW_W, 9, twiddle-address width = log2(N/2) with N=1024.
- TW_STEP, 1, twiddle address stride = N/(2*DELAY).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample present this cycle.
- in_last  in  1  qualifies in_valid: last sample of the final frame.
- in_ready  out  1  controller accepts input; 0 only in FLUSH.
- shift_en  out  1  advance the delay line this cycle.
- bf_en  out  1  butterfly phase: delay line holds first half, input is second half.
- tw_en  out  1  output sample needs a twiddle multiply.
- tw_addr  out  TW_W  twiddle ROM address.
- out_valid  out  1  stage output valid this cycle.
- cnt  out  CNT_W  position within frame, 0..2*DELAY-1.
- busy  out  1  state != IDLE.
- frame_done  out  1  one-cycle pulse after the drain completes.
- err  out  1  sticky: in_last accepted off a frame boundary.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, cnt=0, frame_done=0, err=0. All combinational outputs follow from this: shift_en=in_valid, in_ready=1, bf_en=0, tw_en=0, out_valid=0, busy=0.
- States are IDLE, FILL, RUN, FLUSH. State, cnt, frame_done and err are registered; all other outputs are combinational from state, cnt and in_valid (zero-cycle latency to shift_en).
- accept = in_valid && in_ready.
- shift_en = accept in IDLE/FILL/RUN; shift_en = 1 every cycle in FLUSH.
- cnt increments on every shift_en cycle and wraps 2*DELAY-1 → 0; it holds when shift_en=0. Stalls (in_valid=0) in FILL/RUN freeze everything.
- bf_en = shift_en && cnt[CNT_W-1] (cnt ≥ DELAY), in FILL/RUN only.
- out_valid = shift_en && state∈{RUN, FLUSH}.
- tw_en = out_valid && !cnt[CNT_W-1].
- tw_addr = (cnt[CNT_W-2:0] * TW_STEP) modulo 2^TW_W. It is 0 whenever tw_en=0.
- Transitions:
  - IDLE: on accept, go to FILL (cnt 0→1).
  - FILL: on accept at cnt=DELAY-1, go to RUN. The first out_valid therefore coincides with the (DELAY+1)-th accepted sample.
  - RUN, accept at cnt=2*DELAY-1: if in_last, go to FLUSH (cnt→0); else stay in RUN and wrap cnt.
  - RUN or FILL, accept with in_last at any other cnt: set err (sticky until reset), ignore in_last, continue normally.
  - FLUSH: in_ready=0 and input is ignored. Runs exactly DELAY cycles (cnt 0..DELAY-1) with out_valid=tw_en=1. At cnt=DELAY-1, go to IDLE with cnt→0 and register frame_done=1 for exactly one cycle.
- In IDLE with in_valid=1 in the same cycle frame_done is high, the sample is accepted normally (back-to-back jobs).
- Reset asserted mid-frame aborts immediately; no frame_done is produced.

Test Plan (DELAY=4, CNT_W=3, TW_W=3, TW_STEP=2 unless stated):
- Reset, then 8 consecutive accepts with in_last on the 8th:
  - shift_en high for 8 cycles; bf_en high on accepts 5-8; out_valid high on accepts 5-8.
  - Then FLUSH for 4 cycles: in_ready=0, out_valid=tw_en=1, tw_addr=0,2,4,6.
  - frame_done pulses the following cycle; busy=0 after.
- Two frames (16 accepts, in_last on the 16th):
  - On accepts 9-12, tw_en=1 with tw_addr=0,2,4,6; bf_en=1 on accepts 13-16.
  - cnt wraps 7→0 with no bubble.
- in_valid low for 3 cycles at cnt=5 in RUN: shift_en=0 and cnt holds 5 throughout; sequence resumes identically.
- in_last on accept 3: err=1 and stays 1; controller continues to RUN; in_last on accept 8 still enters FLUSH.
- rst_n pulsed low during FLUSH at cnt=2: outputs return to reset values asynchronously; no frame_done.
- Default parameters, 1024 accepts plus in_last:
  - bf_en on accepts 513-1024.
  - FLUSH lasts 512 cycles, with tw_addr running 0..511.
